// File: rtl/serpent_pkg.sv
// rtl/serpent_pkg.sv - shared widths, FSM state type and rotate helper for the Serpent round controller
package serpent_pkg;
    localparam int SERPENT_BLK_W  = 128;
    localparam int SERPENT_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [SERPENT_WORD_W-1:0] rotl32(
        input logic [SERPENT_WORD_W-1:0] x,
        input int unsigned               n
    );
        return (x << n) | (x >> (32 - n));
    endfunction
endpackage

// File: rtl/s_box.sv
// rtl/s_box.sv - eight selectable Serpent 4-bit S-boxes applied bitsliced across four 32-bit words
module s_box (
    input  logic [2:0]   i_sel,
    input  logic [127:0] i_data,
    output logic [127:0] o_data
);
    localparam logic [3:0] SBOX [8][16] = '{
        '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB, 4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
        '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA, 4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
        '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF, 4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
        '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3, 4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
        '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6, 4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
        '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC, 4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
        '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB, 4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
        '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB, 4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
    };

    // Column b gathers bit b of each word, word 0 being the least significant nibble bit.
    for (genvar b = 0; b < 32; b++) begin : g_col
        logic [3:0] w_nib;
        assign w_nib = SBOX[i_sel][{i_data[96+b], i_data[64+b], i_data[32+b], i_data[b]}];
        assign o_data[b]    = w_nib[0];
        assign o_data[32+b] = w_nib[1];
        assign o_data[64+b] = w_nib[2];
        assign o_data[96+b] = w_nib[3];
    end
endmodule

// File: rtl/serpent_round_ctrl_lt.sv
// rtl/serpent_round_ctrl_lt.sv - combinational Serpent linear transform on four 32-bit words
module serpent_lt
    import serpent_pkg::*;
(
    input  logic [SERPENT_BLK_W-1:0] i_data,
    output logic [SERPENT_BLK_W-1:0] o_data
);
    logic [31:0] w_x0a, w_x2a, w_x1b, w_x3b, w_x1c, w_x3c, w_x0d, w_x2d, w_x0e, w_x2e;

    assign w_x0a = rotl32(i_data[31:0], 13);
    assign w_x2a = rotl32(i_data[95:64], 3);
    assign w_x1b = i_data[63:32] ^ w_x0a ^ w_x2a;
    assign w_x3b = i_data[127:96] ^ w_x2a ^ (w_x0a << 3);
    assign w_x1c = rotl32(w_x1b, 1);
    assign w_x3c = rotl32(w_x3b, 7);
    assign w_x0d = w_x0a ^ w_x1c ^ w_x3c;
    assign w_x2d = w_x2a ^ w_x3c ^ (w_x1c << 7);
    assign w_x0e = rotl32(w_x0d, 5);
    assign w_x2e = rotl32(w_x2d, 22);

    assign o_data = {w_x3c, w_x2e, w_x1c, w_x0e};
endmodule

// File: rtl/serpent_round_ctrl.sv
// rtl/serpent_round_ctrl.sv - iterative Serpent-128 encryption controller, one round per clock
// Optional SERPENT_ABORT_EN adds an abort input that discards an in-flight block.
module serpent_round_ctrl
    import serpent_pkg::*;
#(
    parameter int NUM_ROUNDS = 32,
    parameter int KIDX_W     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef SERPENT_ABORT_EN
    input  logic                     abort,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SERPENT_BLK_W-1:0] in_data,
    output logic [KIDX_W-1:0]        key_idx,
    input  logic [SERPENT_BLK_W-1:0] key_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SERPENT_BLK_W-1:0] out_data
);
    localparam logic [KIDX_W-1:0] LAST_RND  = KIDX_W'(NUM_ROUNDS - 1);
    localparam logic [KIDX_W-1:0] FINAL_IDX = KIDX_W'(NUM_ROUNDS);

    state_t                   r_state, w_state_n;
    logic [SERPENT_BLK_W-1:0] r_blk, w_blk_n;
    logic [KIDX_W-1:0]        r_rnd, w_rnd_n;
    logic [SERPENT_BLK_W-1:0] r_out_data, w_out_data_n;
    logic                     r_out_valid, w_out_valid_n;

    logic [SERPENT_BLK_W-1:0] w_mix, w_sub, w_lt;

    assign w_mix = r_blk ^ key_in;

    s_box u_s_box (
        .i_sel  (r_rnd[2:0]),
        .i_data (w_mix),
        .o_data (w_sub)
    );

    serpent_lt u_lt (
        .i_data (w_sub),
        .o_data (w_lt)
    );

    // The round counter doubles as the key index, so it is cleared on every return to IDLE.
    always_comb begin
        w_state_n     = r_state;
        w_blk_n       = r_blk;
        w_rnd_n       = r_rnd;
        w_out_data_n  = r_out_data;
        w_out_valid_n = r_out_valid;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_blk_n   = in_data;
                    w_rnd_n   = '0;
                    w_state_n = ROUND;
                end
            end
            ROUND: begin
                if (r_rnd < LAST_RND) begin
                    w_blk_n = w_lt;
                    w_rnd_n = r_rnd + 1'b1;
                end else begin
                    w_blk_n   = w_sub;
                    w_rnd_n   = FINAL_IDX;
                    w_state_n = FINAL;
                end
            end
            FINAL: begin
                w_out_data_n  = w_mix;
                w_out_valid_n = 1'b1;
                w_state_n     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_out_valid_n = 1'b0;
                    w_rnd_n       = '0;
                    w_state_n     = IDLE;
                end
            end
            default: begin
                w_out_valid_n = 1'b0;
                w_rnd_n       = '0;
                w_state_n     = IDLE;
            end
        endcase
`ifdef SERPENT_ABORT_EN
        if (abort && (r_state == ROUND || r_state == FINAL)) begin
            w_state_n     = IDLE;
            w_blk_n       = '0;
            w_rnd_n       = '0;
            w_out_data_n  = r_out_data;
            w_out_valid_n = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_blk       <= '0;
            r_rnd       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_blk       <= w_blk_n;
            r_rnd       <= w_rnd_n;
            r_out_data  <= w_out_data_n;
            r_out_valid <= w_out_valid_n;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign key_idx   = r_rnd;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
endmodule

// File: tb/tb_serpent_round_ctrl.sv
// tb/tb_serpent_round_ctrl.sv - scoreboard bench for serpent_round_ctrl with a reference cipher model
module tb_serpent_round_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [5:0]   key_idx;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
`ifdef SERPENT_ABORT_EN
    logic         abort;
`endif

    bit           key_zero;
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    serpent_round_ctrl #(.NUM_ROUNDS(32), .KIDX_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SERPENT_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_idx   (key_idx),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    localparam logic [63:0] SB_HEX [8] = '{
        64'h38F1A65BED42709C, 64'hFC27905A1BE86D34, 64'h86793CAFD1E40B52, 64'h0FB8C963D124A75E,
        64'h1F83C0B6254A9E7D, 64'hF52B4A9C03E8D671, 64'h72C5846BE91FD3A0, 64'h1DF0E82B74CA9356
    };

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] key_of(input logic [5:0] idx, input bit zero);
        logic [31:0] s;
        s = 32'h9E3779B9 * (32'(idx) + 32'd1);
        if (zero) return '0;
        return {s ^ 32'h0F0F0F0F, ~s, rl(s, 11), s};
    endfunction

    always_comb key_in = key_of(key_idx, key_zero);

    function automatic logic [127:0] sbox128(input int s, input logic [127:0] x);
        logic [127:0] y;
        logic [63:0]  t;
        logic [3:0]   v;
        int           xi;
        t = SB_HEX[s];
        y = '0;
        for (int i = 0; i < 32; i++) begin
            xi = int'({x[96+i], x[64+i], x[32+i], x[i]});
            v  = t[63-4*xi -: 4];
            y[i] = v[0]; y[32+i] = v[1]; y[64+i] = v[2]; y[96+i] = v[3];
        end
        return y;
    endfunction

    function automatic logic [127:0] model_lt(input logic [127:0] b);
        logic [31:0] x0, x1, x2, x3;
        {x3, x2, x1, x0} = b;
        x0 = rl(x0, 13);  x2 = rl(x2, 3);
        x1 = x1 ^ x0 ^ x2; x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = rl(x1, 1);   x3 = rl(x3, 7);
        x0 = x0 ^ x1 ^ x3; x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = rl(x0, 5);   x2 = rl(x2, 22);
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input bit zero);
        logic [127:0] b;
        b = pt;
        for (int r = 0; r < 32; r++) begin
            b = sbox128(r % 8, b ^ key_of(6'(r), zero));
            if (r < 31) b = model_lt(b);
        end
        return b ^ key_of(6'd32, zero);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("scoreboard_unexpected_output", 128'(exp_q.size()), 128'd1);
            else chk("ciphertext", out_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [127:0] pt);
        int n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        if (!in_ready) chk("send_ready_timeout", 128'(in_ready), 128'd1);
        exp_q.push_back(model_enc(pt, key_zero));
        in_valid = 1'b1; in_data = pt;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 300) begin tick(); n++; end
        chk("drain_complete", 128'(exp_q.size() == 0 && in_ready), 128'd1);
    endtask

    initial begin
        int lat, n, busy_hi, ov_seen;
        logic [127:0] e2;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; key_zero = 1'b1;
`ifdef SERPENT_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_key_idx", 128'(key_idx), 128'd0);
        rst = 1'b0;
        tick();

        // Known answer: zero key, zero block, consumer always ready.
        out_ready = 1'b1;
        exp_q.push_back(model_enc('0, 1'b1));
        in_valid = 1'b1; in_data = '0;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            chk("key_idx_trace", 128'(key_idx), 128'(lat - 1));
            tick(); lat++;
        end
        chk("latency", 128'(lat), 128'd34);
        chk("done_key_idx", 128'(key_idx), 128'd32);
        chk("done_in_ready", 128'(in_ready), 128'd0);
        tick();
        chk("ack_out_valid", 128'(out_valid), 128'd0);
        chk("ack_in_ready", 128'(in_ready), 128'd1);
        chk("idle_key_idx", 128'(key_idx), 128'd0);

        // Backpressure with a non-zero key schedule.
        key_zero = 1'b0; out_ready = 1'b0;
        e2 = model_enc(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0);
        send(128'h0123456789ABCDEF_FEDCBA9876543210);
        n = 0;
        while (!out_valid && n < 60) begin tick(); n++; end
        chk("bp_out_valid_rise", 128'(out_valid), 128'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_data_stable", out_data, e2);
            chk("bp_in_ready_low", 128'(in_ready), 128'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_ack_out_valid", 128'(out_valid), 128'd0);
        chk("bp_ack_in_ready", 128'(in_ready), 128'd1);
        chk("bp_scoreboard_empty", 128'(exp_q.size()), 128'd0);

        // A block offered during ROUND is held off until IDLE.
        out_ready = 1'b1;
        send(128'hDEADBEEF_00000001_CAFEF00D_80000000);
        repeat (5) tick();
        exp_q.push_back(model_enc(128'hFFFFFFFF_00000000_A5A5A5A5_12345678, 1'b0));
        in_valid = 1'b1; in_data = 128'hFFFFFFFF_00000000_A5A5A5A5_12345678;
        n = 0; busy_hi = 0;
        while (!in_ready && n < 100) begin
            if (in_ready) busy_hi++;
            tick(); n++;
        end
        chk("ignored_first_done", 128'(exp_q.size()), 128'd1);
        chk("ignored_wait_cycles", 128'(n), 128'd29);
        tick();
        in_valid = 1'b0;
        chk("ignored_second_accepted", 128'(in_ready), 128'd0);
        drain();

        // Synchronous reset in the middle of round 15.
        send(128'h00000000_11111111_22222222_33333333);
        n = 0;
        while (key_idx != 6'd15 && n < 60) begin tick(); n++; end
        chk("midrst_reach_rnd15", 128'(key_idx), 128'd15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_out_data", out_data, 128'd0);
        chk("midrst_key_idx", 128'(key_idx), 128'd0);
        send(128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978);
        drain();

`ifdef SERPENT_ABORT_EN
        send(128'h89ABCDEF_01234567_76543210_FEDCBA98);
        n = 0;
        while (key_idx != 6'd20 && n < 60) begin tick(); n++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_key_idx", 128'(key_idx), 128'd0);
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) ov_seen++;
            tick();
        end
        chk("abort_no_out_valid", 128'(ov_seen), 128'd0);
        abort = 1'b1;
        send(128'h55555555_AAAAAAAA_33333333_CCCCCCCC);
        abort = 1'b0;
        chk("abort_idle_accepted", 128'(in_ready), 128'd0);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
